spi_responder: RTL and testbench
================================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth on sclk/mosi/_ss (legal 2..3).
REQ-002 Parameter IDLE_FILL, default 8'hFF, byte shifted out when no tx byte is queued.
REQ-003 clk  input  1  system clock, single clock domain; sclk frequency SHALL NOT exceed clk/6.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sclk  input  1  SPI clock from initiator, mode 0 (CPOL=0, CPHA=0), asynchronous.
REQ-006 mosi  input  1  SPI data from initiator, MSB first, asynchronous.
REQ-007 _ss  input  1  slave select, active-low, asynchronous.
REQ-008 miso  output  1  SPI data to initiator.
REQ-009 miso_oe  output  1  miso drive enable; high only while synchronized _ss is low.
REQ-010 tx_data  input  8  next byte to transmit.
REQ-011 tx_valid  input  1  tx_data is valid; accepted when tx_valid & tx_ready.
REQ-012 tx_ready  output  1  holding register empty.
REQ-013 rx_data  output  8  last received byte, held until next byte completes.
REQ-014 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-015 rx_overrun  output  1  sticky: byte completed while previous rx_valid unacknowledged.
REQ-016 rx_ack  input  1  clears pending-byte flag and rx_overrun.
REQ-017 crc_reset  input  1  clears CRC register to 16'h0000.
REQ-018 crc_out  output  16  CRC16-CCITT (poly 16'h1021, init 0, no reflect, no xorout) over received bytes.
REQ-019 active  output  1  synchronized _ss is low.

Function
REQ-020 sclk, mosi, _ss SHALL pass through SYNC_STAGES flops; edges detected by comparing last sync stage with one further flop.
REQ-021 States: IDLE (_ss high), ARMED (_ss low, bit count 0, MSB presented), SHIFT (bits 1..7); _ss rising from any state -> IDLE next cycle.
REQ-022 IDLE->ARMED on _ss falling edge: tx byte loaded into shift register (holding register if full, else IDLE_FILL), miso = bit 7.
REQ-023 On each sclk rising edge: sample synchronized mosi into rx shift LSB, increment 3-bit bit counter.
REQ-024 On each sclk falling edge: shift tx register left, miso = next bit; after 8th falling edge reload tx as in REQ-022 (back-to-back bytes, no gap).
REQ-025 On 8th rising edge: rx_data <= assembled byte and rx_valid pulses the following cycle; CRC updated over that byte in the same cycle as rx_data.
REQ-026 Latency: rx_valid SHALL assert exactly SYNC_STAGES+2 clk cycles after the 8th sclk rising edge at the pin.
REQ-027 tx_ready high when holding register empty; tx handshake and reload in same cycle: reload takes the old holding content, new byte stored.
REQ-028 rx_valid while pending flag set -> rx_overrun <= 1, rx_data overwritten; rx_ack same cycle as new byte -> new byte stays pending, overrun not set.
REQ-029 crc_reset simultaneous with CRC update -> result is CRC of that byte from init 0.
REQ-030 _ss rising mid-byte: partial rx bits discarded, no rx_valid, bit counter cleared, partially sent tx byte lost, holding register kept.
REQ-031 sclk edges while _ss high SHALL be ignored.

Reset
REQ-032 rst: state IDLE, counters 0, rx_data 8'h00, rx_valid 0, rx_overrun 0, crc_out 16'h0000, tx holding empty (tx_ready 1), miso 1, miso_oe 0, active 0.
REQ-033 rst mid-transfer aborts the byte without rx_valid; synchronizers cleared to idle levels (sclk 0, _ss 1).

Structure
REQ-034 Shared package: state encoding, CRC polynomial constant 16'h1021, IDLE_FILL default.
REQ-035 One sub-module crc16_ccitt_byte (combinational: crc_in, data byte -> crc_out); all else inline.

Verification
REQ-036 clk/8 sclk, send 8'hA5 with tx 8'h3C queued -> rx_data 8'hA5, one rx_valid, miso bits 0,0,1,1,1,1,0,0.
REQ-037 Send ASCII "123456789" after crc_reset -> crc_out 16'h31C3.
REQ-038 Two bytes 8'h11, 8'h22 without rx_ack -> rx_data 8'h22, rx_overrun 1; rx_ack -> rx_overrun 0.
REQ-039 No tx queued, 2 bytes -> miso returns 8'hFF twice; tx_ready stays 1.
REQ-040 _ss deasserted after 5 bits then new 8-bit 8'h5A -> only 8'h5A received, tx restarts at MSB.
REQ-041 rst asserted mid-byte -> all REQ-032 values next cycle, no rx_valid.

Source files
------------

// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI responder: FSM encoding, CRC polynomial
// and the default byte returned when nothing is queued for transmit.
package spi_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [15:0] CRC16_POLY        = 16'h1021;
    localparam logic [7:0]  IDLE_FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_responder_if.sv
// SPI pin group plus the byte-level tx/rx/CRC handshake of the responder.
interface spi_responder_if;

    logic        sclk;
    logic        mosi;
    logic        _ss;
    logic        miso;
    logic        miso_oe;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overrun;
    logic        rx_ack;
    logic        crc_reset;
    logic [15:0] crc_out;
    logic        active;

    modport slave (
        input  sclk, mosi, _ss, tx_data, tx_valid, rx_ack, crc_reset,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, crc_out, active
    );

    modport master (
        output sclk, mosi, _ss, tx_data, tx_valid, rx_ack, crc_reset,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, crc_out, active
    );

endinterface

// File: rtl/spi_responder_crc.sv
// Combinational CRC16-CCITT step over one byte, MSB first, no reflection.
module crc16_ccitt_byte
    import spi_responder_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] crc;

    always_comb begin
        crc = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc[15] ^ data[3'(7 - i)]) begin
                crc = {crc[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                crc = {crc[14:0], 1'b0};
            end
        end
        crc_out = crc;
    end

endmodule

// File: rtl/spi_responder.sv
// Mode-0 SPI responder oversampled by clk: synchronized pins, byte framing,
// tx holding register, rx byte handoff with overrun flag and running CRC16.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_FILL   = IDLE_FILL_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    spi_responder_if.slave bus
);

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall, ss_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus._ss};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;

    state_t      state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic [7:0]  hold_data, hold_data_n;
    logic        hold_full, hold_full_n;
    logic [6:0]  rx_shift, rx_shift_n;
    logic [7:0]  rx_data_q, rx_data_n;
    logic        byte_done, byte_done_n;
    logic        rx_valid_q, rx_valid_n;
    logic        rx_pending, rx_pending_n;
    logic        rx_overrun_q, rx_overrun_n;
    logic [15:0] crc_q, crc_n;

    logic [7:0]  rx_byte;
    logic [15:0] crc_seed, crc_calc;
    logic [7:0]  reload_byte;
    logic        tx_accept;
    logic        reload;

    assign rx_byte     = {rx_shift, mosi_s};
    // Seeding from zero lets a crc_reset coincident with a byte restart the CRC on it.
    assign crc_seed    = bus.crc_reset ? '0 : crc_q;
    assign reload_byte = hold_full ? hold_data : IDLE_FILL;
    assign tx_accept   = bus.tx_valid & ~hold_full;

    crc16_ccitt_byte u_crc (
        .crc_in  (crc_seed),
        .data    (rx_byte),
        .crc_out (crc_calc)
    );

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        tx_shift_n   = tx_shift;
        rx_shift_n   = rx_shift;
        rx_data_n    = rx_data_q;
        byte_done_n  = 1'b0;
        crc_n        = bus.crc_reset ? '0 : crc_q;
        reload       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_n    = ST_ARMED;
                    bit_cnt_n  = '0;
                    tx_shift_n = reload_byte;
                    reload     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (sclk_rise) begin
                    state_n    = ST_SHIFT;
                    bit_cnt_n  = 3'd1;
                    rx_shift_n = {rx_shift[5:0], mosi_s};
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    bit_cnt_n  = bit_cnt + 3'd1;
                    rx_shift_n = {rx_shift[5:0], mosi_s};
                    if (bit_cnt == 3'd7) begin
                        rx_data_n   = rx_byte;
                        crc_n       = crc_calc;
                        byte_done_n = 1'b1;
                    end
                end else if (sclk_fall) begin
                    // bit_cnt wrapped to 0 on the 8th rise: this fall starts the next byte
                    if (bit_cnt == 3'd0) begin
                        state_n    = ST_ARMED;
                        tx_shift_n = reload_byte;
                        reload     = 1'b1;
                    end else begin
                        tx_shift_n = {tx_shift[6:0], 1'b1};
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (ss_s && state != ST_IDLE) begin
            state_n     = ST_IDLE;
            bit_cnt_n   = '0;
            rx_shift_n  = '0;
            tx_shift_n  = '1;
            rx_data_n   = rx_data_q;
            crc_n       = bus.crc_reset ? '0 : crc_q;
            byte_done_n = 1'b0;
            reload      = 1'b0;
        end

        hold_full_n  = tx_accept ? 1'b1 : (reload ? 1'b0 : hold_full);
        hold_data_n  = tx_accept ? bus.tx_data : hold_data;

        rx_valid_n   = byte_done;
        rx_pending_n = rx_valid_q ? 1'b1 : (bus.rx_ack ? 1'b0 : rx_pending);
        rx_overrun_n = bus.rx_ack ? 1'b0 : ((rx_valid_q & rx_pending) ? 1'b1 : rx_overrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            tx_shift     <= '1;
            hold_data    <= '0;
            hold_full    <= 1'b0;
            rx_shift     <= '0;
            rx_data_q    <= '0;
            byte_done    <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_pending   <= 1'b0;
            rx_overrun_q <= 1'b0;
            crc_q        <= '0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            tx_shift     <= tx_shift_n;
            hold_data    <= hold_data_n;
            hold_full    <= hold_full_n;
            rx_shift     <= rx_shift_n;
            rx_data_q    <= rx_data_n;
            byte_done    <= byte_done_n;
            rx_valid_q   <= rx_valid_n;
            rx_pending   <= rx_pending_n;
            rx_overrun_q <= rx_overrun_n;
            crc_q        <= crc_n;
        end
    end

    assign bus.miso       = tx_shift[7];
    assign bus.miso_oe    = ~ss_s;
    assign bus.active     = ~ss_s;
    assign bus.tx_ready   = ~hold_full;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_overrun = rx_overrun_q;
    assign bus.crc_out    = crc_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: SPI initiator at clk/8 with hand-computed
// expected bytes, CRC values, latency and flag behaviour.
module tb_spi_responder;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   rxv_cnt = 0;

    spi_responder_if bus ();

    spi_responder #(
        .SYNC_STAGES (2),
        .IDLE_FILL   (8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rx_valid === 1'b1) rxv_cnt <= rxv_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_xfer(input int nbits, input logic [7:0] mo, input bit crc_pulse,
                            output logic [7:0] mi, output int lat);
        mi  = '0;
        lat = 0;
        for (int b = 0; b < nbits; b++) begin
            bus.mosi = mo[7-b];
            repeat (4) @(negedge clk);
            bus.sclk  = 1'b1;
            mi[7-b]   = bus.miso;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (crc_pulse && b == 7) bus.crc_reset = (k == 2);
                if (bus.rx_valid === 1'b1 && lat == 0) lat = k;
            end
            bus.sclk = 1'b0;
        end
    endtask

    task automatic ss_begin();
        bus._ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_end();
        repeat (4) @(negedge clk);
        bus._ss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic queue_tx(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_rx_data"},    32'(bus.rx_data),    32'h00);
        check({pfx, "_rx_valid"},   32'(bus.rx_valid),   32'h0);
        check({pfx, "_rx_overrun"}, 32'(bus.rx_overrun), 32'h0);
        check({pfx, "_crc_out"},    32'(bus.crc_out),    32'h0000);
        check({pfx, "_tx_ready"},   32'(bus.tx_ready),   32'h1);
        check({pfx, "_miso"},       32'(bus.miso),       32'h1);
        check({pfx, "_miso_oe"},    32'(bus.miso_oe),    32'h0);
        check({pfx, "_active"},     32'(bus.active),     32'h0);
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mi0, mi1;
        int         lat;
        int         cnt0;
        string      digits;

        rst           = 1'b1;
        bus.sclk      = 1'b0;
        bus.mosi      = 1'b0;
        bus._ss       = 1'b1;
        bus.tx_data   = '0;
        bus.tx_valid  = 1'b0;
        bus.rx_ack    = 1'b0;
        bus.crc_reset = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_values("reset");

        // A5 in, 3C out
        queue_tx(8'h3C);
        check("a5_tx_ready_queued", 32'(bus.tx_ready), 32'h0);
        ss_begin();
        check("a5_active", 32'(bus.active), 32'h1);
        check("a5_miso_oe", 32'(bus.miso_oe), 32'h1);
        check("a5_tx_ready_loaded", 32'(bus.tx_ready), 32'h1);
        spi_xfer(8, 8'hA5, 1'b0, mi, lat);
        check("a5_miso_bits", 32'(mi), 32'h3C);
        check("a5_rx_data", 32'(bus.rx_data), 32'hA5);
        check("a5_latency", 32'(lat), 32'd4);
        check("a5_crc", 32'(bus.crc_out), 32'hE54F);
        ss_end();
        check("a5_rx_valid_count", 32'(rxv_cnt), 32'd1);
        check("a5_active_off", 32'(bus.active), 32'h0);
        check("a5_miso_oe_off", 32'(bus.miso_oe), 32'h0);

        // CRC check string, ack held so nothing overruns
        bus.crc_reset = 1'b1;
        @(negedge clk);
        bus.crc_reset = 1'b0;
        @(negedge clk);
        check("crc_cleared", 32'(bus.crc_out), 32'h0000);
        digits = "123456789";
        cnt0 = rxv_cnt;
        bus.rx_ack = 1'b1;
        ss_begin();
        for (int i = 0; i < 9; i++) begin
            spi_xfer(8, digits[i], 1'b0, mi, lat);
            if (i == 0) mi0 = mi;
            if (i == 1) mi1 = mi;
        end
        ss_end();
        bus.rx_ack = 1'b0;
        check("crc_check_value", 32'(bus.crc_out), 32'h31C3);
        check("crc_rx_data", 32'(bus.rx_data), 32'h39);
        check("crc_rx_count", 32'(rxv_cnt - cnt0), 32'd9);
        check("crc_overrun_acked", 32'(bus.rx_overrun), 32'h0);
        check("fill_byte0", 32'(mi0), 32'hFF);
        check("fill_byte1", 32'(mi1), 32'hFF);
        check("fill_tx_ready", 32'(bus.tx_ready), 32'h1);

        // crc_reset in the same cycle as the byte update
        ss_begin();
        spi_xfer(8, 8'h31, 1'b1, mi, lat);
        ss_end();
        check("crc_reset_coincident", 32'(bus.crc_out), 32'h2672);
        check("crc_reset_rx_data", 32'(bus.rx_data), 32'h31);

        // overrun
        pulse_ack();
        check("ovr_cleared_start", 32'(bus.rx_overrun), 32'h0);
        ss_begin();
        spi_xfer(8, 8'h11, 1'b0, mi, lat);
        check("ovr_first_data", 32'(bus.rx_data), 32'h11);
        check("ovr_first_flag", 32'(bus.rx_overrun), 32'h0);
        spi_xfer(8, 8'h22, 1'b0, mi, lat);
        ss_end();
        check("ovr_second_data", 32'(bus.rx_data), 32'h22);
        check("ovr_set", 32'(bus.rx_overrun), 32'h1);
        pulse_ack();
        check("ovr_ack_clears", 32'(bus.rx_overrun), 32'h0);

        // sclk activity with _ss high is ignored
        cnt0 = rxv_cnt;
        bus.mosi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        check("ss_high_no_rx", 32'(rxv_cnt - cnt0), 32'd0);
        check("ss_high_rx_data", 32'(bus.rx_data), 32'h22);

        // abort after 5 bits, then full byte 5A
        queue_tx(8'h96);
        cnt0 = rxv_cnt;
        ss_begin();
        queue_tx(8'hC3);
        check("abort_hold_full", 32'(bus.tx_ready), 32'h0);
        spi_xfer(5, 8'hE7, 1'b0, mi, lat);
        check("abort_partial_miso", 32'(mi), 32'h90);
        ss_end();
        check("abort_no_rx", 32'(rxv_cnt - cnt0), 32'd0);
        check("abort_hold_kept", 32'(bus.tx_ready), 32'h0);
        ss_begin();
        spi_xfer(8, 8'h5A, 1'b0, mi, lat);
        ss_end();
        check("abort_rx_data", 32'(bus.rx_data), 32'h5A);
        check("abort_rx_count", 32'(rxv_cnt - cnt0), 32'd1);
        check("abort_tx_restart", 32'(mi), 32'hC3);

        // rst in the middle of a byte
        ss_begin();
        queue_tx(8'h77);
        check("rst_hold_full", 32'(bus.tx_ready), 32'h0);
        cnt0 = rxv_cnt;
        spi_xfer(4, 8'hF0, 1'b0, mi, lat);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        bus._ss = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_rx", 32'(rxv_cnt - cnt0), 32'd0);
        check("midrst_rx_data_after", 32'(bus.rx_data), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
